pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 5, number of pipeline stages; pipeline register k sits between stage k and k+1, k=0..NSTAGES-2.
REQ-002 SHALL have parameter MA_REG, default 3, index of the register flushed on a D-cache miss.
REQ-003 SHALL have parameter BR_REG, default 2, count of younger registers (0..BR_REG-1) flushed on redirect.
REQ-004 SHALL have parameter LU_REG, default 1, index of the register bubbled on load-use.
REQ-005 SHALL have parameter CNTW, default 16, width of the stall counters.
REQ-006 SHALL have parameter TIMEOUT, default 255, consecutive D-miss cycles that raise an error.
REQ-007 SHALL use one clock and an asynchronous, active-low reset.
REQ-008 Clk  input  1  clock, rising edge.
REQ-009 Rst  input  1  asynchronous active-low reset.
REQ-010 i_ICache_Miss  input  1  fetch miss, level.
REQ-011 i_DCache_Miss  input  1  memory-access miss, level.
REQ-012 i_LoadUse  input  1  load-use hazard detected this cycle.
REQ-013 i_Redirect  input  1  single-cycle mispredict/jump pulse.
REQ-014 i_CntClr  input  1  synchronous clear of counters.
REQ-015 o_PC_Stall  output  1  hold PC.
REQ-016 o_Stall  output  NSTAGES-1  per-register hold.
REQ-017 o_Flush  output  NSTAGES-1  per-register bubble load.
REQ-018 o_IStallCnt, o_DStallCnt  output  CNTW each  saturating cause counters.
REQ-019 o_MissErr  output  1  sticky D-miss timeout flag.

Function
REQ-020 o_PC_Stall, o_Stall, o_Flush SHALL be combinational from inputs and registered state, with zero-cycle latency.
REQ-021 Priority per cycle SHALL be: D-miss > redirect (live or pending) > load-use > I-miss > run.
REQ-022 Run: all control outputs SHALL be 0.
REQ-023 D-miss: o_PC_Stall=1; o_Stall[k]=1 for k<MA_REG; o_Flush[MA_REG]=1; all other bits 0.
REQ-024 i_Redirect during D-miss SHALL set register pend_redir; the redirect SHALL be applied on the first cycle with i_DCache_Miss=0, then pend_redir SHALL clear.
REQ-025 Redirect (live pulse, or pending with D-miss low): o_Flush[k]=1 for k<BR_REG; o_PC_Stall=0; o_Stall all 0; this overrides load-use and I-miss that cycle.
REQ-026 Load-use: o_PC_Stall=1; o_Stall[k]=1 for k<LU_REG; o_Flush[LU_REG]=1.
REQ-027 I-miss only: o_PC_Stall=1; o_Flush[0]=1; later registers advance.
REQ-028 o_DStallCnt SHALL increment each cycle i_DCache_Miss=1; o_IStallCnt SHALL increment each cycle the I-miss action of REQ-027 is applied; both SHALL saturate at 2^CNTW-1.
REQ-029 i_CntClr SHALL zero both counters and take priority over increment; it SHALL NOT clear o_MissErr.
REQ-030 A consecutive-D-miss counter SHALL reset to 0 when i_DCache_Miss=0; o_MissErr SHALL set when this counter reaches TIMEOUT and stay set until reset.
REQ-031 An I-miss and D-miss together SHALL produce the D-miss outputs, and only o_DStallCnt SHALL count.
REQ-032 Parameters SHALL satisfy LU_REG<MA_REG<NSTAGES-1 and BR_REG<=MA_REG, checked at elaboration.

Reset
REQ-033 Asserting Rst low SHALL clear pend_redir, both counters, the timeout counter and o_MissErr asynchronously; a redirect pending at reset SHALL be discarded.
REQ-034 During reset, with inputs low, all control outputs SHALL be 0.

Structure
REQ-035 Default parameter values and the register-index constants (IF/ID=0, ID/EX=1, EX/MA=2, MA/WB=3) SHALL live in the shared pipeline definitions package.
REQ-036 One sub-module, sat_counter (parameter width, with inc, clr and async active-low reset), SHALL be instantiated twice.

Verification
REQ-037 D-miss held 4 cycles with defaults -> o_PC_Stall=1, o_Stall=4'b0111, o_Flush=4'b1000 each cycle; o_DStallCnt=4.
REQ-038 Redirect pulse on cycle 2 of a 3-cycle D-miss -> no flush during the miss; o_Flush=4'b0011 on the first cycle after; pend_redir=0 afterwards.
REQ-039 Load-use and redirect in the same cycle -> o_Flush=4'b0011, o_PC_Stall=0, o_Stall=0.
REQ-040 I-miss 3 cycles -> o_Flush=4'b0001, o_PC_Stall=1; o_IStallCnt=3; i_CntClr with an increment in the same cycle -> counters read 0.
REQ-041 CNTW=4, D-miss 20 cycles -> o_DStallCnt=15; TIMEOUT=10 -> o_MissErr rises after 10 consecutive cycles and stays 1 after the miss clears.
REQ-042 Rst low with pend_redir=1 -> pend_redir cleared; after release, no flush occurs.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: register indices, default stall-controller parameters,
// per-cycle action encoding and the parameter legality check.
package pipe_stall_ctrl_pkg;

  localparam int REG_IF_ID = 0;
  localparam int REG_ID_EX = 1;
  localparam int REG_EX_MA = 2;
  localparam int REG_MA_WB = 3;

  localparam int NSTAGES_DEF = 5;
  localparam int MA_REG_DEF  = REG_MA_WB;
  // A redirect squashes every register younger than EX/MA.
  localparam int BR_REG_DEF  = REG_EX_MA;
  localparam int LU_REG_DEF  = REG_ID_EX;
  localparam int CNTW_DEF    = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ACT_RUN,
    ACT_DMISS,
    ACT_REDIR,
    ACT_LOADUSE,
    ACT_IMISS
  } stall_act_e;

  function automatic bit params_ok(input int nstages, input int ma_reg,
                                   input int br_reg, input int lu_reg);
    return (lu_reg < ma_reg) && (ma_reg < nstages - 1) && (br_reg <= ma_reg);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: resolves D-miss, redirect, load-use and I-miss per cycle.
// Control outputs are combinational (zero latency); counters and the miss-timeout flag are registered.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int MA_REG  = MA_REG_DEF,
  parameter int BR_REG  = BR_REG_DEF,
  parameter int LU_REG  = LU_REG_DEF,
  parameter int CNTW    = CNTW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_ICache_Miss,
  input  logic              i_DCache_Miss,
  input  logic              i_LoadUse,
  input  logic              i_Redirect,
  input  logic              i_CntClr,
  output logic              o_PC_Stall,
  output logic [NSTAGES-2:0] o_Stall,
  output logic [NSTAGES-2:0] o_Flush,
  output logic [CNTW-1:0]   o_IStallCnt,
  output logic [CNTW-1:0]   o_DStallCnt,
  output logic              o_MissErr
);

  localparam int NREG = NSTAGES - 1;
  localparam int TOW  = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT);

  if (!params_ok(NSTAGES, MA_REG, BR_REG, LU_REG) || (TIMEOUT < 1) || (CNTW < 1)) begin : g_param_err
    $error("pipe_stall_ctrl: illegal parameters (need LU_REG<MA_REG<NSTAGES-1, BR_REG<=MA_REG)");
  end

  logic           r_pend_redir;
  logic [TOW-1:0] r_to_cnt;
  logic           r_miss_err;
  stall_act_e     w_act;
  logic           w_imiss_cnt;

  // A redirect seen while the D-miss holds the pipe is parked and replayed once the miss clears.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pend_redir <= 1'b0;
      r_to_cnt     <= '0;
      r_miss_err   <= 1'b0;
    end else begin
      r_pend_redir <= i_DCache_Miss & (r_pend_redir | i_Redirect);
      if (!i_DCache_Miss) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (i_DCache_Miss && (r_to_cnt >= TO_MAX - 1'b1)) begin
        r_miss_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_act = ACT_RUN;
    if (i_DCache_Miss) begin
      w_act = ACT_DMISS;
    end else if (i_Redirect || r_pend_redir) begin
      w_act = ACT_REDIR;
    end else if (i_LoadUse) begin
      w_act = ACT_LOADUSE;
    end else if (i_ICache_Miss) begin
      w_act = ACT_IMISS;
    end
  end

  always_comb begin
    o_PC_Stall = 1'b0;
    o_Stall    = '0;
    o_Flush    = '0;
    for (int k = 0; k < NREG; k++) begin
      case (w_act)
        ACT_DMISS: begin
          o_Stall[k] = (k < MA_REG);
          o_Flush[k] = (k == MA_REG);
        end
        ACT_REDIR: begin
          o_Flush[k] = (k < BR_REG);
        end
        ACT_LOADUSE: begin
          o_Stall[k] = (k < LU_REG);
          o_Flush[k] = (k == LU_REG);
        end
        ACT_IMISS: begin
          o_Flush[k] = (k == REG_IF_ID);
        end
        default: begin
          o_Stall[k] = 1'b0;
          o_Flush[k] = 1'b0;
        end
      endcase
    end
    o_PC_Stall = (w_act == ACT_DMISS) || (w_act == ACT_LOADUSE) || (w_act == ACT_IMISS);
  end

  assign w_imiss_cnt = (w_act == ACT_IMISS);
  assign o_MissErr   = r_miss_err;

  sat_counter #(.WIDTH(CNTW)) u_istall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_inc (w_imiss_cnt),
    .i_clr (i_CntClr),
    .o_cnt (o_IStallCnt)
  );

  sat_counter #(.WIDTH(CNTW)) u_dstall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_inc (i_DCache_Miss),
    .i_clr (i_CntClr),
    .o_cnt (o_DStallCnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (NSTAGES=5 defaults, CNTW=4, TIMEOUT=10).
module tb_pipe_stall_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       im, dm, lu, red, clr;
  logic       o_PC_Stall;
  logic [3:0] o_Stall, o_Flush;
  logic [3:0] o_IStallCnt, o_DStallCnt;
  logic       o_MissErr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pipe_stall_ctrl #(.CNTW(4), .TIMEOUT(10)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .i_ICache_Miss (im),
    .i_DCache_Miss (dm),
    .i_LoadUse     (lu),
    .i_Redirect    (red),
    .i_CntClr      (clr),
    .o_PC_Stall    (o_PC_Stall),
    .o_Stall       (o_Stall),
    .o_Flush       (o_Flush),
    .o_IStallCnt   (o_IStallCnt),
    .o_DStallCnt   (o_DStallCnt),
    .o_MissErr     (o_MissErr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic [3:0] st,
                          input logic [3:0] fl);
    chk({tag, ".pc"},    32'(o_PC_Stall), 32'(pc));
    chk({tag, ".stall"}, 32'(o_Stall),    32'(st));
    chk({tag, ".flush"}, 32'(o_Flush),    32'(fl));
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Rst = 1'b0; im = 1'b0; dm = 1'b0; lu = 1'b0; red = 1'b0; clr = 1'b0;
    #1;
    chk_ctrl("reset", 1'b0, 4'b0000, 4'b0000);
    chk("reset.icnt", 32'(o_IStallCnt), 32'd0);
    chk("reset.dcnt", 32'(o_DStallCnt), 32'd0);
    chk("reset.err",  32'(o_MissErr),   32'd0);
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk_ctrl("run", 1'b0, 4'b0000, 4'b0000);

    // D-miss held four cycles
    for (int i = 0; i < 4; i++) begin
      dm = 1'b1;
      #1;
      chk_ctrl($sformatf("dmiss%0d", i), 1'b1, 4'b0111, 4'b1000);
      tick();
    end
    dm = 1'b0;
    #1;
    chk("dmiss.dcnt", 32'(o_DStallCnt), 32'd4);
    chk_ctrl("dmiss.after", 1'b0, 4'b0000, 4'b0000);

    // Redirect on cycle 2 of a 3-cycle D-miss is deferred
    for (int i = 0; i < 3; i++) begin
      dm  = 1'b1;
      red = (i == 1);
      #1;
      chk_ctrl($sformatf("pend_miss%0d", i), 1'b1, 4'b0111, 4'b1000);
      tick();
    end
    dm = 1'b0; red = 1'b0;
    #1;
    chk_ctrl("pend_apply", 1'b0, 4'b0000, 4'b0011);
    tick();
    chk_ctrl("pend_clear", 1'b0, 4'b0000, 4'b0000);

    // Redirect beats load-use; then load-use alone
    lu = 1'b1; red = 1'b1;
    #1;
    chk_ctrl("redir_lu", 1'b0, 4'b0000, 4'b0011);
    tick();
    red = 1'b0;
    #1;
    chk_ctrl("loaduse", 1'b1, 4'b0001, 4'b0010);
    im = 1'b1;
    #1;
    chk_ctrl("lu_over_im", 1'b1, 4'b0001, 4'b0010);
    tick();
    lu = 1'b0;

    // I-miss for three cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctrl($sformatf("imiss%0d", i), 1'b1, 4'b0000, 4'b0001);
      tick();
    end
    chk("imiss.icnt", 32'(o_IStallCnt), 32'd3);

    // I-miss together with D-miss: D-miss outputs, only D counter moves
    dm = 1'b1;
    #1;
    chk_ctrl("im_dm", 1'b1, 4'b0111, 4'b1000);
    tick();
    dm = 1'b0;
    #1;
    chk("im_dm.icnt", 32'(o_IStallCnt), 32'd3);
    chk("im_dm.dcnt", 32'(o_DStallCnt), 32'd8);

    // Clear with a same-cycle increment wins
    clr = 1'b1;
    tick();
    clr = 1'b0; im = 1'b0;
    #1;
    chk("clr.icnt", 32'(o_IStallCnt), 32'd0);
    chk("clr.dcnt", 32'(o_DStallCnt), 32'd0);

    // 20-cycle D-miss: counter saturates, timeout flag after 10 cycles
    for (int i = 0; i < 20; i++) begin
      dm = 1'b1;
      #1;
      chk($sformatf("err_c%0d", i), 32'(o_MissErr), (i >= 10) ? 32'd1 : 32'd0);
      tick();
    end
    dm = 1'b0;
    #1;
    chk("sat.dcnt", 32'(o_DStallCnt), 32'd15);
    repeat (3) tick();
    chk("err.sticky", 32'(o_MissErr), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("clr.err_kept", 32'(o_MissErr), 32'd1);
    chk("clr.dcnt2",    32'(o_DStallCnt), 32'd0);

    // Redirect parked under a D-miss, then discarded by reset
    dm = 1'b1; red = 1'b1;
    tick();
    red = 1'b0;
    #1;
    Rst = 1'b0; dm = 1'b0;
    #1;
    chk_ctrl("rst_pend", 1'b0, 4'b0000, 4'b0000);
    chk("rst.err",  32'(o_MissErr),   32'd0);
    chk("rst.dcnt", 32'(o_DStallCnt), 32'd0);
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk_ctrl("post_rst0", 1'b0, 4'b0000, 4'b0000);
    tick();
    chk_ctrl("post_rst1", 1'b0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
